// File: rtl/ws2812b_decoder.sv
// WS2812B single-wire NRZ receiver: recovers 24-bit GRB words and frame boundaries.
// Optional DOUT pass-through port data_fwd is enabled by defining WS2812B_DEC_FWD_EN.
module ws2812b_decoder #(
   parameter int N            = 32,
   parameter int IDX_W        = 6,
   parameter int T_GLITCH     = 5,
   parameter int T_BIT_THRESH = 30,
   parameter int T_HIGH_MAX   = 75,
   parameter int T_RESET      = 2500
) (
   input  logic             clk_50,
   input  logic             rst_n,
   input  logic             data_in,
   output logic [23:0]      pixel_data,
   output logic             pixel_valid,
   output logic [IDX_W-1:0] pixel_index,
   output logic             frame_done,
   output logic [IDX_W-1:0] pixel_count,
   output logic             bit_err,
   output logic             overflow
`ifdef WS2812B_DEC_FWD_EN
   ,
   output logic             data_fwd
`endif
);

   localparam int CNT_W = $clog2(T_RESET + 1);
   localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(T_RESET - 1);
   localparam logic [CNT_W-1:0] LOW_SAT   = CNT_W'(T_RESET);
   localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(T_HIGH_MAX - 1);
   localparam logic [CNT_W-1:0] GLITCH_W  = CNT_W'(T_GLITCH);
   localparam logic [CNT_W-1:0] BIT_THR   = CNT_W'(T_BIT_THRESH);
   localparam logic [IDX_W-1:0] PIX_MAX   = IDX_W'(N);

   typedef enum logic [1:0] {S_SYNC, S_LOW, S_HIGH} state_t;

   state_t           state_q, state_d;
   logic             din_meta, din_s;
   logic [CNT_W-1:0] low_cnt, high_cnt;
   logic [23:0]      shift_reg;
   logic [4:0]       bit_cnt;
   logic [IDX_W-1:0] pix_cnt;
   logic             word_ready;

   logic low_inc, low_clr, high_start, high_inc;
   logic take_bit, long_err, gap_end, sync_done;

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         din_meta <= 1'b0;
         din_s    <= 1'b0;
         state_q  <= S_SYNC;
      end else begin
         din_meta <= data_in;
         din_s    <= din_meta;
         state_q  <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      low_inc    = 1'b0;
      low_clr    = 1'b0;
      high_start = 1'b0;
      high_inc   = 1'b0;
      take_bit   = 1'b0;
      long_err   = 1'b0;
      gap_end    = 1'b0;
      sync_done  = 1'b0;
      case (state_q)
         S_SYNC: begin
            if (din_s) begin
               low_clr = 1'b1;
            end else if (low_cnt == LOW_LAST) begin
               sync_done = 1'b1;
               state_d   = S_LOW;
            end else begin
               low_inc = 1'b1;
            end
         end
         S_LOW: begin
            if (din_s) begin
               high_start = 1'b1;
               state_d    = S_HIGH;
            end else begin
               if (low_cnt == LOW_LAST) gap_end = 1'b1;
               if (low_cnt != LOW_SAT) low_inc = 1'b1;
            end
         end
         S_HIGH: begin
            if (din_s) begin
               if (high_cnt == HIGH_LAST) begin
                  long_err = 1'b1;
                  state_d  = S_SYNC;
               end else begin
                  high_inc = 1'b1;
               end
            end else begin
               // Short pulses are glitches: resume the low run without resetting it
               state_d = S_LOW;
               if (high_cnt >= GLITCH_W) take_bit = 1'b1;
            end
         end
         default: state_d = S_SYNC;
      endcase
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         low_cnt     <= '0;
         high_cnt    <= '0;
         shift_reg   <= '0;
         bit_cnt     <= '0;
         pix_cnt     <= '0;
         word_ready  <= 1'b0;
         pixel_data  <= '0;
         pixel_valid <= 1'b0;
         pixel_index <= '0;
         frame_done  <= 1'b0;
         pixel_count <= '0;
         bit_err     <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         bit_err     <= 1'b0;
         word_ready  <= 1'b0;

         if (low_clr || sync_done || long_err || take_bit) low_cnt <= '0;
         else if (low_inc) low_cnt <= low_cnt + 1'b1;

         if (high_start) high_cnt <= CNT_W'(1);
         else if (high_inc) high_cnt <= high_cnt + 1'b1;

         if (take_bit) begin
            shift_reg <= {shift_reg[22:0], (high_cnt >= BIT_THR)};
            if (bit_cnt == 5'd23) begin
               bit_cnt    <= '0;
               word_ready <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 5'd1;
            end
         end

         // Completed word is published one cycle after its last bit lands
         if (word_ready) begin
            if (pix_cnt < PIX_MAX) begin
               pixel_data  <= shift_reg;
               pixel_index <= pix_cnt;
               pixel_valid <= 1'b1;
               pix_cnt     <= pix_cnt + 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end

         if (long_err) begin
            bit_err <= 1'b1;
            bit_cnt <= '0;
         end

         if (sync_done) begin
            bit_cnt  <= '0;
            pix_cnt  <= '0;
            overflow <= 1'b0;
         end

         if (gap_end) begin
            if (bit_cnt != 5'd0) bit_err <= 1'b1;
            if (pix_cnt != '0) begin
               frame_done  <= 1'b1;
               pixel_count <= pix_cnt;
            end
            pix_cnt  <= '0;
            bit_cnt  <= '0;
            overflow <= 1'b0;
         end
      end
   end

`ifdef WS2812B_DEC_FWD_EN
   // Pixel 0 is consumed locally; the line is only repeated once it has been taken
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) data_fwd <= 1'b0;
      else        data_fwd <= (pix_cnt != '0) ? din_s : 1'b0;
   end
`endif

endmodule

// File: tb/tb_ws2812b_decoder.sv
// Scoreboard bench for ws2812b_decoder: drives NRZ frames and checks pixel/frame strobes.
module tb_ws2812b_decoder;

   logic        clk_50 = 1'b0;
   logic        rst_n;
   logic        data_in;
   logic [23:0] pixel_data;
   logic        pixel_valid;
   logic [5:0]  pixel_index;
   logic        frame_done;
   logic [5:0]  pixel_count;
   logic        bit_err;
   logic        overflow;
`ifdef WS2812B_DEC_FWD_EN
   logic        data_fwd;
`endif

   ws2812b_decoder dut (
      .clk_50      (clk_50),
      .rst_n       (rst_n),
      .data_in     (data_in),
      .pixel_data  (pixel_data),
      .pixel_valid (pixel_valid),
      .pixel_index (pixel_index),
      .frame_done  (frame_done),
      .pixel_count (pixel_count),
      .bit_err     (bit_err),
      .overflow    (overflow)
`ifdef WS2812B_DEC_FWD_EN
      ,
      .data_fwd    (data_fwd)
`endif
   );

   always #10 clk_50 = ~clk_50;

   typedef struct packed {
      logic [23:0] data;
      logic [5:0]  idx;
   } pix_t;

   pix_t pixQ[$];
   int   fdQ[$];
   pix_t expPix;
   int   expCount;
   int   checks = 0;
   int   errors = 0;
   int   errSeen = 0;
   int   benchPixCnt = 0;
   int   lowW = 20;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Strobes are consumed against the expectation queues as they appear
   always @(negedge clk_50) begin
      if (rst_n) begin
         if (pixel_valid) begin
            if (pixQ.size() == 0) begin
               checkOutput("spurious_pixel_valid", 32'd1, 32'd0);
            end else begin
               expPix = pixQ.pop_front();
               checkOutput("pixel_data", pixel_data, expPix.data);
               checkOutput("pixel_index", pixel_index, expPix.idx);
            end
         end
         if (frame_done) begin
            if (fdQ.size() == 0) begin
               checkOutput("spurious_frame_done", 32'd1, 32'd0);
            end else begin
               expCount = fdQ.pop_front();
               checkOutput("pixel_count", pixel_count, expCount);
            end
         end
         if (bit_err) errSeen++;
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk_50);
      #1;
   endtask

   task automatic sendBit(input logic b, input logic glitch);
      data_in = 1'b1;
      waitCycles(b ? 40 : 20);
      data_in = 1'b0;
      if (glitch) begin
         waitCycles(8);
         data_in = 1'b1;
         waitCycles(3);
         data_in = 1'b0;
         waitCycles(lowW - 11);
      end else begin
         waitCycles(lowW);
      end
   endtask

   task automatic applyStimulus(input logic [23:0] w, input bit track, input int glitchBit);
      if (track) begin
         if (benchPixCnt < 32) pixQ.push_back({w, 6'(benchPixCnt)});
         benchPixCnt++;
      end
      for (int i = 23; i >= 0; i--) sendBit(w[i], i == glitchBit);
   endtask

   task automatic sendGap(input bit track);
      if (track && benchPixCnt > 0) fdQ.push_back(benchPixCnt > 32 ? 32 : benchPixCnt);
      benchPixCnt = 0;
      data_in = 1'b0;
      waitCycles(2600);
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_pixel_data"}, pixel_data, 24'h0);
      checkOutput({tag, "_pixel_valid"}, pixel_valid, 1'b0);
      checkOutput({tag, "_pixel_index"}, pixel_index, 6'd0);
      checkOutput({tag, "_frame_done"}, frame_done, 1'b0);
      checkOutput({tag, "_pixel_count"}, pixel_count, 6'd0);
      checkOutput({tag, "_bit_err"}, bit_err, 1'b0);
      checkOutput({tag, "_overflow"}, overflow, 1'b0);
   endtask

   initial begin
      rst_n   = 1'b0;
      data_in = 1'b0;
      waitCycles(3);
      checkIdle("reset");
      rst_n = 1'b1;
      waitCycles(2600);

      // Single pixel frame with nominal 40/20 timing
      lowW = 20;
      applyStimulus(24'hFF0000, 1'b1, -1);
      sendGap(1'b1);
      checkOutput("t1_pix_queue_empty", pixQ.size(), 0);
      checkOutput("t1_fd_queue_empty", fdQ.size(), 0);
      checkOutput("t1_pixel_count_held", pixel_count, 6'd1);
      checkOutput("t1_no_bit_err", errSeen, 0);

      // 33 alternating pixels: 32 accepted, the last one overflows
      lowW = 8;
      for (int p = 0; p < 33; p++) begin
         applyStimulus((p % 2) ? 24'h0000AA : 24'h00FF00, 1'b1, -1);
         if (p == 31) checkOutput("t2_no_overflow_at_32", overflow, 1'b0);
      end
      waitCycles(10);
      checkOutput("t2_overflow_set", overflow, 1'b1);
      sendGap(1'b1);
      checkOutput("t2_overflow_cleared", overflow, 1'b0);
      checkOutput("t2_pixel_count_held", pixel_count, 6'd32);
      checkOutput("t2_pix_queue_empty", pixQ.size(), 0);
      checkOutput("t2_fd_queue_empty", fdQ.size(), 0);

      // Glitch pulse in the low phase of one bit is ignored
      lowW = 20;
      applyStimulus(24'h123456, 1'b1, 12);
      sendGap(1'b1);
      checkOutput("t3_pix_queue_empty", pixQ.size(), 0);
      checkOutput("t3_fd_queue_empty", fdQ.size(), 0);
      checkOutput("t3_no_bit_err", errSeen, 0);

      // Over-long high, then traffic ignored until a full reset gap
      data_in = 1'b1;
      waitCycles(80);
      data_in = 1'b0;
      waitCycles(10);
      checkOutput("t4_long_high_err", errSeen, 1);
      applyStimulus(24'hABCDEF, 1'b0, -1);
      sendGap(1'b0);
      checkOutput("t4_ignored_no_err", errSeen, 1);
      applyStimulus(24'h0F0F0F, 1'b1, -1);
      sendGap(1'b1);
      checkOutput("t4_pix_queue_empty", pixQ.size(), 0);
      checkOutput("t4_fd_queue_empty", fdQ.size(), 0);

      // Partial word at the gap
      for (int i = 0; i < 10; i++) sendBit(1'b1, 1'b0);
      sendGap(1'b0);
      checkOutput("t5_partial_err", errSeen, 2);

      // Reset mid-pixel, then a clean frame
      for (int i = 0; i < 12; i++) sendBit(i % 2, 1'b0);
      data_in = 1'b1;
      waitCycles(10);
      rst_n   = 1'b0;
      data_in = 1'b0;
      waitCycles(2);
      checkIdle("midreset");
      rst_n = 1'b1;
      waitCycles(2600);
      applyStimulus(24'hC0FFEE, 1'b1, -1);
      sendGap(1'b1);
      checkOutput("t6_pix_queue_empty", pixQ.size(), 0);
      checkOutput("t6_fd_queue_empty", fdQ.size(), 0);
      checkOutput("t6_err_total", errSeen, 2);
      checkOutput("t6_pixel_count_held", pixel_count, 6'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
